// File: rtl/axis_qm_pkg.sv
// rtl/axis_qm_pkg.sv - shared queue-manager types and constants
package axis_qm_pkg;

    localparam logic [15:0] ETH_TPID_VLAN  = 16'h8100;
    localparam int          SRC_ADDR_WIDTH = 48;
    localparam int          DST_ADDR_WIDTH = 48;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

    typedef struct packed {
        logic [2:0]  port_id;
        logic [11:0] vlan_id;
    } connection_addr_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
// Ports: req (request vector), last_grant (index served last),
//        grant_oh (one-hot winner, 0 when no request), grant_idx (winner index).
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand_idx;

    // Scan last_grant+1, last_grant+2, ... with wrap; the port served last
    // is examined last, which gives the rotational fairness.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand_idx = IDX_W'((int'(last_grant) + i) % N);
            if (!found && req[cand_idx]) begin
                found              = 1'b1;
                grant_oh[cand_idx] = 1'b1;
                grant_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-granular round-robin AXI-Stream arbiter
// Ports: clk/rst (sync active-high); port_en per-port arbitration enable;
//        s_* flattened per-port ingress streams; m_* registered egress stream
//        with m_tuser = source port; vlan_* one pulse per packet with the
//        802.1Q tag result; pkt_cnt flattened 32-bit per-port packet counters.
module axis_pkt_rr_arbiter
    import axis_qm_pkg::*;
#(
    parameter int DATA_SIZE            = 32,
    parameter int NUM_OF_INGRESS_PORTS = 3,
    parameter int PORT_ID_W            = 2,
    parameter int VLAN_BEAT            = (SRC_ADDR_WIDTH + DST_ADDR_WIDTH) / DATA_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_OF_INGRESS_PORTS-1:0]       port_en,
    input  logic [NUM_OF_INGRESS_PORTS-1:0]       s_tvalid,
    output logic [NUM_OF_INGRESS_PORTS-1:0]       s_tready,
    input  logic [NUM_OF_INGRESS_PORTS*DATA_SIZE-1:0]   s_tdata,
    input  logic [NUM_OF_INGRESS_PORTS*DATA_SIZE/8-1:0] s_tkeep,
    input  logic [NUM_OF_INGRESS_PORTS-1:0]       s_tlast,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [DATA_SIZE-1:0]                  m_tdata,
    output logic [DATA_SIZE/8-1:0]                m_tkeep,
    output logic                                  m_tlast,
    output logic [PORT_ID_W-1:0]                  m_tuser,
    output logic                                  vlan_valid,
    output logic                                  vlan_tagged,
    output logic [11:0]                           vlan_id,
    output logic [NUM_OF_INGRESS_PORTS*32-1:0]    pkt_cnt
);

    localparam int N      = NUM_OF_INGRESS_PORTS;
    localparam int KEEP_W = DATA_SIZE / 8;
    localparam int BEAT_W = $clog2(VLAN_BEAT + 2);

    arb_state_t             state_q, state_d;
    logic [PORT_ID_W-1:0]   grant_q, grant_d;
    logic [PORT_ID_W-1:0]   last_grant_q, last_grant_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic [DATA_SIZE-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]      m_tkeep_q, m_tkeep_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [PORT_ID_W-1:0]   m_tuser_q, m_tuser_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                   vlan_valid_q, vlan_valid_d;
    logic                   vlan_tagged_q, vlan_tagged_d;
    logic [11:0]            vlan_id_q, vlan_id_d;
    logic [N-1:0][31:0]     pkt_cnt_q, pkt_cnt_d;

    logic [N-1:0]           pick_oh;
    logic [PORT_ID_W-1:0]   pick_idx;
    logic                   out_ready;
    logic                   sel_tvalid;
    logic                   sel_tlast;
    logic [DATA_SIZE-1:0]   sel_tdata;
    logic [KEEP_W-1:0]      sel_tkeep;
    logic                   beat_acc;
    logic                   tpid_match;

    rr_pick #(
        .N     (N),
        .IDX_W (PORT_ID_W)
    ) u_rr_pick (
        .req        (s_tvalid & port_en),
        .last_grant (last_grant_q),
        .grant_oh   (pick_oh),
        .grant_idx  (pick_idx)
    );

    // Single registered egress stage: it can take a beat when empty or
    // when its current beat leaves this cycle.
    assign out_ready  = !m_tvalid_q || m_tready;
    assign sel_tvalid = s_tvalid[grant_q];
    assign sel_tlast  = s_tlast[grant_q];
    assign sel_tdata  = s_tdata[int'(grant_q)*DATA_SIZE +: DATA_SIZE];
    assign sel_tkeep  = s_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
    assign beat_acc   = (state_q == ARB_XFER) && sel_tvalid && out_ready;

    // TPID arrives byte 12 first in the low lane, so 0x8100 shows as 81,00.
    assign tpid_match = (sel_tdata[7:0] == ETH_TPID_VLAN[15:8]) &&
                        (sel_tdata[15:8] == ETH_TPID_VLAN[7:0]);

    always_comb begin
        s_tready = '0;
        if (state_q == ARB_XFER) begin
            s_tready[grant_q] = out_ready;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tlast_d     = m_tlast_q;
        m_tuser_d     = m_tuser_q;
        beat_cnt_d    = beat_cnt_q;
        vlan_valid_d  = 1'b0;
        vlan_tagged_d = vlan_tagged_q;
        vlan_id_d     = vlan_id_q;
        pkt_cnt_d     = pkt_cnt_q;

        if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (|pick_oh) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (beat_acc) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = sel_tdata;
                    m_tkeep_d  = sel_tkeep;
                    m_tlast_d  = sel_tlast;
                    m_tuser_d  = grant_q;

                    if (beat_cnt_q != BEAT_W'(VLAN_BEAT + 1)) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end

                    // Exactly one pulse: either at the tag beat, or at an
                    // early tlast for packets too short to carry a tag.
                    if (beat_cnt_q == BEAT_W'(VLAN_BEAT)) begin
                        vlan_valid_d  = 1'b1;
                        vlan_tagged_d = tpid_match;
                        vlan_id_d     = tpid_match ? {sel_tdata[19:16], sel_tdata[31:24]} : 12'h000;
                    end else if (sel_tlast && (beat_cnt_q < BEAT_W'(VLAN_BEAT))) begin
                        vlan_valid_d  = 1'b1;
                        vlan_tagged_d = 1'b0;
                        vlan_id_d     = 12'h000;
                    end

                    if (sel_tlast) begin
                        last_grant_d       = grant_q;
                        pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
                        state_d            = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            last_grant_q  <= PORT_ID_W'(N - 1);
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tlast_q     <= 1'b0;
            m_tuser_q     <= '0;
            beat_cnt_q    <= '0;
            vlan_valid_q  <= 1'b0;
            vlan_tagged_q <= 1'b0;
            vlan_id_q     <= '0;
            pkt_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tlast_q     <= m_tlast_d;
            m_tuser_q     <= m_tuser_d;
            beat_cnt_q    <= beat_cnt_d;
            vlan_valid_q  <= vlan_valid_d;
            vlan_tagged_q <= vlan_tagged_d;
            vlan_id_q     <= vlan_id_d;
            pkt_cnt_q     <= pkt_cnt_d;
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign m_tkeep     = m_tkeep_q;
    assign m_tlast     = m_tlast_q;
    assign m_tuser     = m_tuser_q;
    assign vlan_valid  = vlan_valid_q;
    assign vlan_tagged = vlan_tagged_q;
    assign vlan_id     = vlan_id_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter. Shares one AXI-Stream egress between NUM_OF_INGRESS_PORTS per-port packet buffers.
- Sits between the per-port ingress buffers and the egress stream of the queue manager.
- A grant is held from the first beat to the accepted tlast beat, so packets are never interleaved.
- Tags every egress beat with the source port id.
- Extracts the 802.1Q VLAN id of each packet.
- Keeps per-port forwarded-packet counters.

Parameters:
- DATA_SIZE, 32, tdata width in bits; tkeep is DATA_SIZE/8.
- NUM_OF_INGRESS_PORTS, 3, number of requesting ingress buffers (2..8).
- PORT_ID_W, 2, width of the port id carried on m_tuser; must satisfy 2**PORT_ID_W >= NUM_OF_INGRESS_PORTS.
- VLAN_BEAT, 3, beat index holding bytes 12..15, equal to (48+48)/DATA_SIZE.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- port_en  in  NUM_OF_INGRESS_PORTS  per-port arbitration enable, sampled only at arbitration.
- s_tvalid  in  NUM_OF_INGRESS_PORTS  per-port valid.
- s_tready  out  NUM_OF_INGRESS_PORTS  per-port ready.
- s_tdata  in  NUM_OF_INGRESS_PORTS*DATA_SIZE  flattened; port i occupies [i*DATA_SIZE +: DATA_SIZE].
- s_tkeep  in  NUM_OF_INGRESS_PORTS*DATA_SIZE/8  flattened likewise.
- s_tlast  in  NUM_OF_INGRESS_PORTS  per-port end of packet.
- m_tvalid  out  1  egress valid.
- m_tready  in  1  egress ready.
- m_tdata  out  DATA_SIZE  egress data.
- m_tkeep  out  DATA_SIZE/8  egress keep.
- m_tlast  out  1  egress end of packet.
- m_tuser  out  PORT_ID_W  source port id, constant for the whole packet.
- vlan_valid  out  1  one-cycle pulse per packet.
- vlan_tagged  out  1  packet carries TPID 0x8100.
- vlan_id  out  12  VID when tagged, else 0.
- pkt_cnt  out  NUM_OF_INGRESS_PORTS*32  flattened per-port forwarded-packet counters.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; last_grant resets to NUM_OF_INGRESS_PORTS-1, so port 0 wins first.
  - m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, vlan_* and every pkt_cnt are cleared to 0; s_tready=0.
  - Reset mid-packet truncates the packet with no tlast on egress. Upstream buffers must be reset together with this block.
- State machine, 2 states:
  - IDLE: req = s_tvalid & port_en. If req!=0, grant = first set bit of req scanning from last_grant+1 upward with wrap; register grant; go to XFER. If req==0, stay in IDLE.
  - XFER: forward beats of the granted port only. On an accepted beat with s_tlast=1: last_grant <= grant, the port's pkt_cnt increments (32-bit, wraps), go to IDLE.
- Latency and throughput:
  - One arbitration cycle precedes every packet, giving exactly one idle cycle between back-to-back packets.
  - Minimum first-beat latency: s_tvalid high at cycle N, s_tready high at cycle N+1, beat on m_* at N+2.
  - One beat per cycle inside a packet when m_tready is held high.
- Handshake (egress is one registered output stage):
  - In XFER, s_tready[grant] = !m_tvalid | m_tready; all other s_tready bits are 0. In IDLE all s_tready bits are 0.
  - Input beat accepted: m_* load the beat, m_tvalid <= 1, m_tuser <= grant.
  - m_tready=1 and no new beat: m_tvalid <= 0.
  - m_* hold stable while m_tvalid=1 and m_tready=0.
- Gaps and enables:
  - s_tvalid may drop mid-packet; the grant is held and no other port is served.
  - Deasserting port_en mid-packet has no effect until that packet's tlast.
- VLAN extraction:
  - A beat counter counts accepted beats of the current packet and saturates at VLAN_BEAT+1.
  - On the accepted beat at index VLAN_BEAT: tagged = (tdata[7:0]==8'h81 && tdata[15:8]==8'h00); vlan_id = tagged ? {tdata[19:16], tdata[31:24]} : 0; vlan_valid pulses the next cycle.
  - Packet ending before VLAN_BEAT: vlan_valid pulses after tlast with tagged=0, vlan_id=0.
  - Exactly one vlan_valid pulse per packet.
- Simultaneous events: when all enabled ports request, the grant order is strictly rotational (0,1,2,0,...). A port that starts requesting during XFER waits for the next arbitration.

Decomposition:
- Shared package axis_qm_pkg:
  - ETH_TPID_VLAN = 16'h8100.
  - SRC_ADDR_WIDTH = 48, DST_ADDR_WIDTH = 48.
  - arb_state_t enum {ARB_IDLE, ARB_XFER}.
  - connection_addr_t struct {port_id, vlan_id}.
- Sub-module rr_pick: combinational round-robin priority picker, inputs req and last_grant, outputs a one-hot grant and its index. Reused by later schedulers.

Test Plan:
- Reset then 3 ports each hold a 5-beat packet, m_tready=1 -> egress order port 0,1,2; m_tuser = 0,1,2; one idle cycle between packets; pkt_cnt = 1,1,1.
- Port 1 packet, beat 3 tdata=32'h2301_0081 -> vlan_valid pulse, vlan_tagged=1, vlan_id=12'h123.
- 2-beat packet on port 2 -> vlan_valid pulse, vlan_tagged=0, vlan_id=0; m_tlast on beat 2.
- m_tready toggled 1,0,0,1 mid-packet -> m_* stable while stalled; no beat lost or duplicated; s_tready[grant] low exactly when m_tvalid=1 and m_tready=0.
- port_en=3'b101, all ports requesting for 6 packets -> order 0,2,0,2,0,2; s_tready[1] never asserted.
- rst asserted on beat 2 of a 6-beat packet -> next cycle m_tvalid=0, pkt_cnt=0; after release, port 0 is granted first.
